fft_input_buffer: RTL and testbench

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_sample_bank.sv | 70 +++++++
 rtl/fft_input_buffer.sv | 154 +++++++++++++++
 tb/tb_fft_input_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT front-end.
//   DEF_FORMAT_WIDTH : default bits per real/imag sample
//   FFT_NPOINT       : complex samples per frame (fixed at 32)
//   PTR_W            : slot index width
//   SIZE_W           : width of the FFT size code
//   bitrev5()        : 5-bit bit reversal used for bit-reversed slot mapping
package fft_pkg;

    localparam int unsigned DEF_FORMAT_WIDTH = 9;
    localparam int unsigned FFT_NPOINT       = 32;
    localparam int unsigned PTR_W            = 5;
    localparam int unsigned SIZE_W           = 12;

    // Reverse the bit order of a 5-bit slot index.
    function automatic logic [PTR_W-1:0] bitrev5(input logic [PTR_W-1:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One frame bank: NP complex sample registers, a written-slot mask and
// zero-padded read-out (slots not written since the last clear read as 0).
// Ports:
//   clk, rst           : clock, async active-low reset (clears the mask)
//   wr_en_i, wr_slot_i : write strobe and target slot
//   wr_real_i/imag_i   : sample to store
//   clr_i              : frame consumed, forget all written slots
//   rd_real_o/imag_o   : packed frame, slot s at [W*(s+1)-1:W*s]
module fft_sample_bank
    import fft_pkg::*;
#(
    parameter int unsigned W  = DEF_FORMAT_WIDTH,
    parameter int unsigned NP = FFT_NPOINT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [PTR_W-1:0]  wr_slot_i,
    input  logic [W-1:0]      wr_real_i,
    input  logic [W-1:0]      wr_imag_i,
    input  logic              clr_i,
    output logic [W*NP-1:0]   rd_real_o,
    output logic [W*NP-1:0]   rd_imag_o
);

    logic [NP-1:0][W-1:0] real_q;
    logic [NP-1:0][W-1:0] imag_q;
    logic [NP-1:0]        mask_q;
    logic [NP-1:0]        mask_d;

    // Written-slot mask: clear on consume, set on write.
    always_comb begin
        mask_d = mask_q;
        if (clr_i) begin
            mask_d = '0;
        end
        if (wr_en_i) begin
            mask_d[wr_slot_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Sample storage; contents are only visible through the mask, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            real_q[wr_slot_i] <= wr_real_i;
            imag_q[wr_slot_i] <= wr_imag_i;
        end
    end

    // Zero-padded read-out.
    always_comb begin
        rd_real_o = '0;
        rd_imag_o = '0;
        for (int s = 0; s < int'(NP); s++) begin
            if (mask_q[s]) begin
                rd_real_o[s*W +: W] = real_q[s];
                rd_imag_o[s*W +: W] = imag_q[s];
            end
        end
    end

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer in front of the FFT core. Samples stream in on a
// valid/ready port and fill one bank while the other is presented as a whole
// frame; short frames (in_last) are zero-padded.
// Build option: FFT_INPUT_BITREV_EN stores sample k in slot bitrev5(k)
// instead of slot k.
// Ports:
//   clk, rst                        : clock, async active-low reset
//   in_valid/in_ready               : sample handshake
//   in_real/in_imag/in_last         : sample payload, short-frame end marker
//   fft_size                        : size code, captured with a frame's first sample
//   input_real/input_imag           : presented frame, slot s at [W*(s+1)-1:W*s]
//   fft_size_out                    : size code of the presented frame
//   out_valid/out_ready             : frame handshake
//   start                           : pulse on first cycle of each presented frame
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int unsigned FORMAT_WIDTH = DEF_FORMAT_WIDTH,
    parameter int unsigned NPOINT       = FFT_NPOINT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FORMAT_WIDTH-1:0]        in_real,
    input  logic [FORMAT_WIDTH-1:0]        in_imag,
    input  logic                           in_last,
    input  logic [SIZE_W-1:0]              fft_size,
    output logic [FORMAT_WIDTH*NPOINT-1:0] input_real,
    output logic [FORMAT_WIDTH*NPOINT-1:0] input_imag,
    output logic [SIZE_W-1:0]              fft_size_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           start
);

    localparam int unsigned FW = FORMAT_WIDTH * NPOINT;

    logic [1:0]             full_q, full_d;
    logic                   fill_sel_q, fill_sel_d;
    logic                   rd_sel_q, rd_sel_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0][SIZE_W-1:0] size_q, size_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   start_q, start_d;

    logic                   accept;
    logic                   hs;
    logic                   done;
    logic [PTR_W-1:0]       wr_slot;
    logic [FW-1:0]          bank0_real, bank0_imag, bank1_real, bank1_imag;

`ifdef FFT_INPUT_BITREV_EN
    assign wr_slot = bitrev5(wr_ptr_q);
`else
    assign wr_slot = wr_ptr_q;
`endif

    // Bank roles, fill pointer and registered handshake outputs.
    // Banks fill and drain strictly alternately, so the read side just toggles.
    always_comb begin
        full_d     = full_q;
        fill_sel_d = fill_sel_q;
        rd_sel_d   = rd_sel_q;
        wr_ptr_d   = wr_ptr_q;
        size_d     = size_q;

        accept = in_valid && in_ready_q;
        hs     = out_valid_q && out_ready;
        done   = accept && (in_last || (wr_ptr_q == PTR_W'(NPOINT - 1)));

        if (hs) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        if (accept) begin
            if (wr_ptr_q == '0) begin
                size_d[fill_sel_q] = fft_size;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (done) begin
            full_d[fill_sel_q] = 1'b1;
            wr_ptr_d           = '0;
            fill_sel_d         = ~fill_sel_q;
        end

        in_ready_d  = !full_d[fill_sel_d];
        out_valid_d = full_d[rd_sel_d];
        // New frame on the output: rising valid, or back-to-back after a handshake.
        start_d     = out_valid_d && (!out_valid_q || hs);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q      <= '0;
            fill_sel_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_ptr_q    <= '0;
            size_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            full_q      <= full_d;
            fill_sel_q  <= fill_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_ptr_q    <= wr_ptr_d;
            size_q      <= size_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            start_q     <= start_d;
        end
    end

    fft_sample_bank #(
        .W  (FORMAT_WIDTH),
        .NP (NPOINT)
    ) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept && !fill_sel_q),
        .wr_slot_i (wr_slot),
        .wr_real_i (in_real),
        .wr_imag_i (in_imag),
        .clr_i     (hs && !rd_sel_q),
        .rd_real_o (bank0_real),
        .rd_imag_o (bank0_imag)
    );

    fft_sample_bank #(
        .W  (FORMAT_WIDTH),
        .NP (NPOINT)
    ) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept && fill_sel_q),
        .wr_slot_i (wr_slot),
        .wr_real_i (in_real),
        .wr_imag_i (in_imag),
        .clr_i     (hs && rd_sel_q),
        .rd_real_o (bank1_real),
        .rd_imag_o (bank1_imag)
    );

    assign input_real   = rd_sel_q ? bank1_real : bank0_real;
    assign input_imag   = rd_sel_q ? bank1_imag : bank0_imag;
    assign fft_size_out = size_q[rd_sel_q];
    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign start        = start_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: the driver pushes each completed
// expected frame into a queue; a negedge monitor checks start and pops/compares
// a frame on every out_valid&&out_ready.
module tb_fft_input_buffer;

    localparam int unsigned W  = 9;
    localparam int unsigned NP = 32;
    localparam int unsigned FW = W * NP;

    typedef struct packed {
        logic [FW-1:0] re;
        logic [FW-1:0] im;
        logic [11:0]   size;
    } frame_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_real;
    logic [W-1:0]  in_imag;
    logic          in_last;
    logic [11:0]   fft_size;
    logic [FW-1:0] input_real;
    logic [FW-1:0] input_imag;
    logic [11:0]   fft_size_out;
    logic          out_valid;
    logic          out_ready;
    logic          start;

    int     vectors;
    int     miscompares;
    frame_t exp_q[$];
    frame_t cur;
    int     cur_idx;
    logic [11:0] cur_size;

    fft_input_buffer #(
        .FORMAT_WIDTH (W),
        .NPOINT       (NP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .in_last      (in_last),
        .fft_size     (fft_size),
        .input_real   (input_real),
        .input_imag   (input_imag),
        .fft_size_out (fft_size_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .start        (start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int map_slot(input int idx);
        logic [4:0] k;
        k = 5'(idx);
`ifdef FFT_INPUT_BITREV_EN
        return int'({k[0], k[1], k[2], k[3], k[4]});
`else
        return int'(k);
`endif
    endfunction

    // Reference model of the frame being assembled; pushes on completion.
    task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im,
                                input logic last, input logic [11:0] sz);
        int s;
        s = map_slot(cur_idx);
        if (cur_idx == 0) cur_size = sz;
        cur.re[s*W +: W] = re;
        cur.im[s*W +: W] = im;
        if (cur_idx == 31 || last) begin
            cur.size = cur_size;
            exp_q.push_back(cur);
            cur     = '0;
            cur_idx = 0;
        end else begin
            cur_idx++;
        end
    endtask

    // Present one sample and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic last, input logic [11:0] sz);
        int  n;
        bit  acc;
        n   = 0;
        acc = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        in_last  = last;
        fft_size = sz;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (acc) begin
            model_accept(re, im, last, sz);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d frames pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: start pulse and frame content at each handshake.
    logic   prev_valid;
    logic   prev_hs;
    logic   exp_start;
    frame_t got;
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            exp_start = out_valid && (!prev_valid || prev_hs);
            if (out_valid || start) check("start", FW'(start), FW'(exp_start));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got out_valid=1 expected no frame");
                end else begin
                    got = exp_q.pop_front();
                    check("frame_real", input_real, got.re);
                    check("frame_imag", input_imag, got.im);
                    check("frame_size", FW'(fft_size_out), FW'(got.size));
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

`ifdef FFT_INPUT_BITREV_EN
    localparam int SLOT_S1 = 16;
    localparam int SLOT_S3 = 24;
`else
    localparam int SLOT_S1 = 1;
    localparam int SLOT_S3 = 3;
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur         = '0;
        cur_idx     = 0;
        cur_size    = '0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        in_last   = 1'b0;
        fft_size  = '0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", FW'(out_valid), FW'(0));
        check("rst_start", FW'(start), FW'(0));
        check("rst_size_out", FW'(fft_size_out), FW'(0));
        check("rst_real", input_real, FW'(0));
        check("rst_imag", input_imag, FW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", FW'(in_ready), FW'(1));

        // Full frame: real=k, imag=-k, back-to-back, out_ready=1.
        for (int k = 0; k < 32; k++) send(W'(k), W'(-k), 1'b0, 12'd5);
        check("full_latency_valid", FW'(out_valid), FW'(1));
        check("full_latency_start", FW'(start), FW'(1));
        drain();

        // Short frame: 5 samples, last on the 5th.
        for (int k = 0; k < 5; k++) send(W'(10 + k), W'(20 + k), (k == 4), 12'd3);
        check("short_latency_valid", FW'(out_valid), FW'(1));
        check("short_slot_s1", FW'(input_real[SLOT_S1*W +: W]), FW'(11));
        check("short_slot_s3", FW'(input_real[SLOT_S3*W +: W]), FW'(13));
        check("short_slot_pad", FW'(input_real[5*W +: W]), FW'(0));
        drain();

        // Backpressure: 64 samples with out_ready=0.
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) begin
            send(W'(k + 100), W'(~k), 1'b0, 12'd7);
            if (k == 31) check("bp_ready_after_32", FW'(in_ready), FW'(1));
        end
        check("bp_ready_after_64", FW'(in_ready), FW'(0));
        fork
            send(W'(70), W'(71), 1'b0, 12'd9);
            begin
                repeat (4) @(negedge clk);
                check("bp_stalled", FW'(in_ready), FW'(0));
                check("bp_hold_valid", FW'(out_valid), FW'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(W'(72), W'(73), 1'b0, 12'd1);
        send(W'(74), W'(75), 1'b1, 12'd1);
        drain();

        // Reset mid-frame discards the partial frame.
        for (int k = 0; k < 10; k++) send(W'(k + 1), W'(k + 2), 1'b0, 12'd4);
        rst = 1'b0;
        #1;
        check("midrst_valid", FW'(out_valid), FW'(0));
        check("midrst_real", input_real, FW'(0));
        cur     = '0;
        cur_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_valid", FW'(out_valid), FW'(0));
        check("postrst_ready", FW'(in_ready), FW'(1));
        for (int k = 0; k < 32; k++) send(W'(200 + k), W'(k + 3), 1'b0, 12'd6);
        drain();

        // fft_size captured only with the first sample of each frame.
        send(W'(1), W'(2), 1'b0, 12'd8);
        send(W'(3), W'(4), 1'b0, 12'hFFF);
        send(W'(5), W'(6), 1'b1, 12'hFFF);
        send(W'(7), W'(8), 1'b1, 12'd2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
